// File: rtl/sc_frog_position_register_pkg.sv
// Shared constants for the frog position register and the display path.
package sc_frog_position_register_pkg;

    localparam int DEF_ROWS      = 8;
    localparam int DEF_COLS      = 8;
    localparam int DEF_START_COL = 3;
    localparam int DEF_SCORE_W   = 4;

    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;
    localparam logic [1:0] SHIFT_HOLD  = 2'b11;

    // Decoded command after applying clear > load0 > load1 > shift priority.
    typedef enum logic [2:0] {
        CMD_IDLE,
        CMD_CLEAR,
        CMD_UP,
        CMD_DOWN,
        CMD_SHIFT
    } frogCmd_e;

    function automatic frogCmd_e decodeCmd(input logic clearLow, input logic load0Low,
                                           input logic load1Low, input logic [1:0] shiftSel);
        if (!clearLow)                                          return CMD_CLEAR;
        else if (!load0Low)                                     return CMD_UP;
        else if (!load1Low)                                     return CMD_DOWN;
        else if (shiftSel == SHIFT_LEFT || shiftSel == SHIFT_RIGHT) return CMD_SHIFT;
        else                                                    return CMD_IDLE;
    endfunction

endpackage

// File: rtl/sc_frog_position_register_shifter.sv
// One-hot column shifter that saturates at either playfield edge instead of wrapping.
module sc_onehot_sat_shifter
    import sc_frog_position_register_pkg::*;
#(
    parameter int COLS = DEF_COLS
) (
    input  logic [COLS-1:0] colCurrent,
    input  logic [1:0]      shiftDir,
    output logic [COLS-1:0] colNext
);

    always_comb begin
        colNext = colCurrent;
        case (shiftDir)
            SHIFT_LEFT:  if (!colCurrent[COLS-1]) colNext = colCurrent << 1;
            SHIFT_RIGHT: if (!colCurrent[0])      colNext = colCurrent >> 1;
            SHIFT_HOLD:  colNext = colCurrent;
            default:     colNext = colCurrent;
        endcase
    end

endmodule

// File: rtl/sc_frog_position_register.sv
// Frog position on the playfield: row/column registers, goal pulse and saturating score,
// updated by one prioritized movement command per clock.
module sc_frog_position_register
    import sc_frog_position_register_pkg::*;
#(
    parameter int ROWS      = DEF_ROWS,
    parameter int COLS      = DEF_COLS,
    parameter int START_COL = DEF_START_COL,
    parameter int SCORE_W   = DEF_SCORE_W
) (
    input  logic                    SC_FROGPOSITION_CLOCK_50,
    input  logic                    SC_FROGPOSITION_RESET_InHigh,
    input  logic                    SC_FROGPOSITION_clear_InLow,
    input  logic                    SC_FROGPOSITION_load0_InLow,
    input  logic                    SC_FROGPOSITION_load1_InLow,
    input  logic [1:0]              SC_FROGPOSITION_shiftselection_In,
    output logic [$clog2(ROWS)-1:0] SC_FROGPOSITION_row_Out,
    output logic [COLS-1:0]         SC_FROGPOSITION_col_Out,
    output logic                    SC_FROGPOSITION_FirstRegister_OutLow,
    output logic                    SC_FROGPOSITION_goal_OutHigh,
    output logic [SCORE_W-1:0]      SC_FROGPOSITION_score_Out
);

    localparam int RW = $clog2(ROWS);
    localparam logic [RW-1:0]      ROW_LAST_STEP = RW'(ROWS - 2);
    localparam logic [COLS-1:0]    COL_START     = COLS'(1) << START_COL;
    localparam logic [SCORE_W-1:0] SCORE_MAX     = '1;

    logic [RW-1:0]      rowReg;
    logic [COLS-1:0]    colReg;
    logic [COLS-1:0]    colShifted;
    logic [SCORE_W-1:0] scoreReg;
    logic               goalReg;
    frogCmd_e           cmd;

    assign cmd = decodeCmd(SC_FROGPOSITION_clear_InLow, SC_FROGPOSITION_load0_InLow,
                           SC_FROGPOSITION_load1_InLow, SC_FROGPOSITION_shiftselection_In);

    sc_onehot_sat_shifter #(
        .COLS(COLS)
    ) u_shifter (
        .colCurrent(colReg),
        .shiftDir  (SC_FROGPOSITION_shiftselection_In),
        .colNext   (colShifted)
    );

    always_ff @(posedge SC_FROGPOSITION_CLOCK_50 or posedge SC_FROGPOSITION_RESET_InHigh) begin
        if (SC_FROGPOSITION_RESET_InHigh) begin
            rowReg   <= '0;
            colReg   <= COL_START;
            scoreReg <= '0;
            goalReg  <= 1'b0;
        end else begin
            goalReg <= 1'b0;
            case (cmd)
                CMD_CLEAR: begin
                    rowReg   <= '0;
                    colReg   <= COL_START;
                    scoreReg <= '0;
                end
                CMD_UP: begin
                    // The goal row is never occupied: stepping onto it scores and restarts.
                    if (rowReg >= ROW_LAST_STEP) begin
                        rowReg  <= '0;
                        colReg  <= COL_START;
                        goalReg <= 1'b1;
                        if (scoreReg != SCORE_MAX) scoreReg <= scoreReg + 1'b1;
                    end else begin
                        rowReg <= rowReg + 1'b1;
                    end
                end
                CMD_DOWN: begin
                    if (rowReg != '0) rowReg <= rowReg - 1'b1;
                end
                CMD_SHIFT: colReg <= colShifted;
                default: ;
            endcase
        end
    end

    assign SC_FROGPOSITION_row_Out              = rowReg;
    assign SC_FROGPOSITION_col_Out              = colReg;
    assign SC_FROGPOSITION_score_Out            = scoreReg;
    assign SC_FROGPOSITION_goal_OutHigh         = goalReg;
    assign SC_FROGPOSITION_FirstRegister_OutLow = (rowReg != '0);

endmodule

// File: tb/tb_sc_frog_position_register.sv
// Self-checking bench: directed vector table, hand sequences, and random stimulus vs a model.
module tb_sc_frog_position_register;

    localparam int ROWS = 8, COLS = 8, START_COL = 3, SCORE_W = 4;
    localparam int SMAX = (1 << SCORE_W) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clrL = 1'b1, ld0L = 1'b1, ld1L = 1'b1;
    logic [1:0] sh = 2'b00;
    logic [2:0] row;
    logic [7:0] col;
    logic       firstL, goal;
    logic [3:0] score;

    int nTests = 0;
    int nFail  = 0;

    int mRow, mColIdx, mScore, mGoal;

    typedef struct {
        logic       c, l0, l1;
        logic [1:0] sh;
        int         row, col, goal, score;
    } vec_t;
    vec_t vecs[$];

    sc_frog_position_register #(
        .ROWS(ROWS), .COLS(COLS), .START_COL(START_COL), .SCORE_W(SCORE_W)
    ) dut (
        .SC_FROGPOSITION_CLOCK_50            (clk),
        .SC_FROGPOSITION_RESET_InHigh        (rst),
        .SC_FROGPOSITION_clear_InLow         (clrL),
        .SC_FROGPOSITION_load0_InLow         (ld0L),
        .SC_FROGPOSITION_load1_InLow         (ld1L),
        .SC_FROGPOSITION_shiftselection_In   (sh),
        .SC_FROGPOSITION_row_Out             (row),
        .SC_FROGPOSITION_col_Out             (col),
        .SC_FROGPOSITION_FirstRegister_OutLow(firstL),
        .SC_FROGPOSITION_goal_OutHigh        (goal),
        .SC_FROGPOSITION_score_Out           (score)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chkAll(input string tag, input int eRow, input int eCol,
                          input int eGoal, input int eScore);
        chk({tag, " row"},   32'(row),    eRow);
        chk({tag, " col"},   32'(col),    eCol);
        chk({tag, " goal"},  32'(goal),   eGoal);
        chk({tag, " score"}, 32'(score),  eScore);
        chk({tag, " first"}, 32'(firstL), (eRow != 0) ? 1 : 0);
    endtask

    task automatic step(input logic c, input logic l0, input logic l1, input logic [1:0] s);
        clrL = c; ld0L = l0; ld1L = l1; sh = s;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic c, input logic l0, input logic l1, input logic [1:0] s,
                       input int eRow, input int eCol, input int eGoal, input int eScore);
        vec_t v;
        v.c = c; v.l0 = l0; v.l1 = l1; v.sh = s;
        v.row = eRow; v.col = eCol; v.goal = eGoal; v.score = eScore;
        vecs.push_back(v);
    endtask

    // Reference model in game terms: row number, column index, goal count.
    task automatic modelReset();
        mRow = 0; mColIdx = START_COL; mScore = 0; mGoal = 0;
    endtask

    task automatic modelApply(input logic c, input logic l0, input logic l1, input logic [1:0] s);
        mGoal = 0;
        if (!c) modelReset();
        else if (!l0) begin
            if (mRow + 1 == ROWS - 1) begin
                mRow = 0; mColIdx = START_COL; mGoal = 1;
                if (mScore < SMAX) mScore++;
            end else mRow++;
        end else if (!l1) begin
            if (mRow > 0) mRow--;
        end else if (s == 2'b01) begin
            if (mColIdx < COLS - 1) mColIdx++;
        end else if (s == 2'b10) begin
            if (mColIdx > 0) mColIdx--;
        end
    endtask

    initial begin
        // Directed table: from reset, up to goal, column saturation, priority.
        for (int i = 1; i <= 6; i++) add(1, 0, 1, 2'b00, i, 8'h08, 0, 0);
        add(1, 0, 1, 2'b00, 0, 8'h08, 1, 1);
        add(1, 1, 1, 2'b00, 0, 8'h08, 0, 1);
        add(1, 1, 1, 2'b01, 0, 8'h10, 0, 1);
        add(1, 1, 1, 2'b01, 0, 8'h20, 0, 1);
        add(1, 1, 1, 2'b01, 0, 8'h40, 0, 1);
        add(1, 1, 1, 2'b01, 0, 8'h80, 0, 1);
        add(1, 1, 1, 2'b01, 0, 8'h80, 0, 1);
        add(1, 1, 1, 2'b10, 0, 8'h40, 0, 1);
        add(1, 1, 1, 2'b10, 0, 8'h20, 0, 1);
        add(1, 1, 1, 2'b10, 0, 8'h10, 0, 1);
        add(1, 1, 1, 2'b10, 0, 8'h08, 0, 1);
        add(1, 1, 1, 2'b10, 0, 8'h04, 0, 1);
        add(1, 1, 1, 2'b10, 0, 8'h02, 0, 1);
        add(1, 1, 1, 2'b10, 0, 8'h01, 0, 1);
        add(1, 1, 1, 2'b10, 0, 8'h01, 0, 1);
        add(1, 1, 0, 2'b00, 0, 8'h01, 0, 1);
        add(1, 0, 1, 2'b00, 1, 8'h01, 0, 1);
        add(1, 1, 0, 2'b00, 0, 8'h01, 0, 1);
        add(1, 0, 1, 2'b00, 1, 8'h01, 0, 1);
        add(0, 0, 1, 2'b01, 0, 8'h08, 0, 0);
        add(1, 0, 0, 2'b00, 1, 8'h08, 0, 0);
        add(1, 1, 1, 2'b11, 1, 8'h08, 0, 0);
        add(1, 1, 0, 2'b10, 0, 8'h08, 0, 0);
        add(1, 1, 1, 2'b00, 0, 8'h08, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chkAll("reset", 0, 8'h08, 0, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].c, vecs[i].l0, vecs[i].l1, vecs[i].sh);
            chkAll($sformatf("vec%0d", i), vecs[i].row, vecs[i].col, vecs[i].goal, vecs[i].score);
        end

        // Asynchronous reset mid-game, observed before the next edge.
        step(1, 0, 1, 2'b00);
        step(1, 1, 1, 2'b01);
        chkAll("pre-reset", 1, 8'h10, 0, 0);
        #2 rst = 1'b1;
        #1;
        chkAll("async reset", 0, 8'h08, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 1, 2'b00);
        chkAll("post-reset first cmd", 1, 8'h08, 0, 0);

        // Sixteen goal crossings: score saturates, goal keeps pulsing.
        step(0, 1, 1, 2'b00);
        for (int k = 1; k <= 16; k++) begin
            repeat (ROWS - 2) step(1, 0, 1, 2'b00);
            chk($sformatf("sat row %0d", k), 32'(row), ROWS - 2);
            step(1, 0, 1, 2'b00);
            chk($sformatf("sat goal %0d", k), 32'(goal), 1);
            chk($sformatf("sat score %0d", k), 32'(score), (k < SMAX) ? k : SMAX);
            chk($sformatf("sat row0 %0d", k), 32'(row), 0);
        end
        step(1, 1, 1, 2'b00);
        chk("goal drops", 32'(goal), 0);
        step(0, 1, 1, 2'b00);
        chkAll("clear after sat", 0, 8'h08, 0, 0);

        // Random stimulus against the model.
        modelReset();
        for (int n = 0; n < 600; n++) begin
            logic c, l0, l1;
            logic [1:0] s;
            c  = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
            l0 = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            l1 = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            s  = 2'($urandom_range(0, 3));
            modelApply(c, l0, l1, s);
            step(c, l0, l1, s);
            chkAll($sformatf("rand%0d", n), mRow, 1 << mColIdx, mGoal, mScore);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
